// File: rtl/psum_wb_addr_gen.sv
// psum_wb_addr_gen
// ----------------
// Purpose: generates SRAM write-back addresses and enables for partial-sum
// results. One pass writes DEPTH rows for each of two output groups. Group 1
// runs SKEW cycles behind group 0. The first row arrives LAT cycles after a
// start is accepted.
//
// Optional feature (compile-time macro WB_BASE_ADDR_EN):
//   defined   -> base_addr input present. It is sampled when start is accepted
//                and added (mod 2^ADDR_W) to every enabled write address.
//   undefined -> no base_addr port; the base is 0.
//
// Ports:
//   clk            in   single clock, rising edge
//   rst_n          in   synchronous active-low reset
//   start          in   one-cycle pass request (honoured only when idle)
//   stall          in   freezes the pass for the current cycle
//   base_addr      in   [ADDR_W] write base (only with WB_BASE_ADDR_EN)
//   sram_waddr_o0  out  [ADDR_W] group-0 write address (queues 0~3)
//   sram_waddr_o1  out  [ADDR_W] group-1 write address (queues 4~7)
//   sram_wen_o0    out  group-0 write enable
//   sram_wen_o1    out  group-1 write enable
//   busy           out  pass in progress, aligned with the write outputs
//   done           out  pulse on the final write of a pass
module psum_wb_addr_gen #(
  parameter int ADDR_W = 10,
  parameter int DEPTH  = 99,
  parameter int SKEW   = 4,
  parameter int LAT    = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              stall,
`ifdef WB_BASE_ADDR_EN
  input  logic [ADDR_W-1:0] base_addr,
`endif
  output logic [ADDR_W-1:0] sram_waddr_o0,
  output logic [ADDR_W-1:0] sram_waddr_o1,
  output logic              sram_wen_o0,
  output logic              sram_wen_o1,
  output logic              busy,
  output logic              done
);

  localparam int LAST  = DEPTH + SKEW - 1;
  localparam int CNT_W = (LAST > 0) ? $clog2(LAST + 1) : 1;

  localparam logic [ADDR_W-1:0] PARK      = ADDR_W'(127);
  localparam logic [7:0]        WAIT_LAST = 8'(LAT - 1);
  localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(LAST);

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    WRITE
  } state_t;

  state_t                 state_reg, state_next;
  logic [7:0]             wait_cnt_reg, wait_cnt_next;
  logic [CNT_W-1:0]       cnt_reg, cnt_next;
  logic [1:0]             wen_reg, wen_next;
  logic [1:0][ADDR_W-1:0] waddr_reg, waddr_next;
  logic                   busy_reg;
  logic                   done_reg, done_next;
  logic [ADDR_W-1:0]      base_cur;
  logic                   accept;

  // The state machine is already back in IDLE while the final write is still
  // on the registered outputs. Gating on busy_reg keeps a start in that cycle
  // from being honoured, so passes never overlap on the outputs.
  assign accept = (state_reg == IDLE) && start && !busy_reg;

`ifdef WB_BASE_ADDR_EN
  logic [ADDR_W-1:0] base_reg;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      base_reg <= '0;
    end else if (accept) begin
      base_reg <= base_addr;
    end
  end

  assign base_cur = base_reg;
`else
  assign base_cur = '0;
`endif

  // Next-state logic. A stall in WAIT or WRITE holds both counters.
  always_comb begin
    state_next    = state_reg;
    wait_cnt_next = wait_cnt_reg;
    cnt_next      = cnt_reg;
    done_next     = 1'b0;
    case (state_reg)
      IDLE: begin
        if (accept) begin
          state_next    = WAIT;
          wait_cnt_next = '0;
          cnt_next      = '0;
        end
      end
      WAIT: begin
        if (!stall) begin
          wait_cnt_next = wait_cnt_reg + 8'd1;
          // This increment is the LAT-th one: the first array row arrives next.
          if (wait_cnt_reg == WAIT_LAST) begin
            state_next = WRITE;
            cnt_next   = '0;
          end
        end
      end
      WRITE: begin
        if (!stall) begin
          if (cnt_reg == CNT_LAST) begin
            state_next = IDLE;
            cnt_next   = '0;
            done_next  = 1'b1;
          end else begin
            cnt_next = cnt_reg + CNT_W'(1);
          end
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Group write windows. Group 0 covers cnt 0..DEPTH-1. Group 1 covers
  // SKEW..DEPTH+SKEW-1, with its address rebased to start from 0.
  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_grp
      localparam int LO = (gi == 0) ? 0 : SKEW;
      localparam int HI = (gi == 0) ? DEPTH - 1 : LAST;

      logic              in_win;
      logic [ADDR_W-1:0] rel;

      assign in_win = (state_reg == WRITE) && !stall &&
                      (int'(cnt_reg) >= LO) && (int'(cnt_reg) <= HI);
      assign rel    = ADDR_W'(int'(cnt_reg) - LO);

      assign wen_next[gi]   = in_win;
      assign waddr_next[gi] = in_win ? (rel + base_cur) : PARK;
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg    <= IDLE;
      wait_cnt_reg <= '0;
      cnt_reg      <= '0;
      wen_reg      <= '0;
      waddr_reg    <= {PARK, PARK};
      busy_reg     <= 1'b0;
      done_reg     <= 1'b0;
    end else begin
      state_reg    <= state_next;
      wait_cnt_reg <= wait_cnt_next;
      cnt_reg      <= cnt_next;
      wen_reg      <= wen_next;
      waddr_reg    <= waddr_next;
      busy_reg     <= (state_reg != IDLE);
      done_reg     <= done_next;
    end
  end

  assign sram_wen_o0   = wen_reg[0];
  assign sram_wen_o1   = wen_reg[1];
  assign sram_waddr_o0 = waddr_reg[0];
  assign sram_waddr_o1 = waddr_reg[1];
  assign busy          = busy_reg;
  assign done          = done_reg;

endmodule
